// File: rtl/inst_fetch_unit.sv
// Purpose: RV64I fetch stage; owns the PC, issues one imem request at a time, presents a registered instruction to decode.
// Latency: request handshake to inst_valid = memory latency + 1 cycle; zero-wait memory yields one instruction per 3 cycles.
// Backpressure: the request address is held until imem_req_ready; the instruction is held in HOLD until inst_ready.
//
// Ports:
//   clk, rst_n                     clock and synchronous active-low reset
//   imem_req_valid/ready/addr      fetch request channel (addr = pc, word aligned)
//   imem_rsp_valid/data/error      fetch response channel (one response per accepted request)
//   inst_valid/ready               instruction handshake toward decode
//   inst, inst_pc, inst_pc_plus4   instruction and its PC / PC+4 (mod 2^64)
//   fetch_fault, fetch_misalign    trap flags, qualified by inst_valid
//   redirect_valid/target          taken branch/jump, loads a new PC
// Build option: FETCH_MISALIGN_TRAP_EN turns a misaligned redirect into a fetch_misalign trap
// instead of silently clearing target[1:0].
module inst_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_0040_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_error,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  output logic [63:0] inst_pc_plus4,
  output logic        fetch_fault,
  output logic        fetch_misalign,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_target
);

  typedef enum logic [1:0] {
    S_REQ       = 2'd0,
    S_WAIT      = 2'd1,
    S_WAIT_KILL = 2'd2,
    S_HOLD      = 2'd3
  } state_t;

  state_t      state;
  logic [63:0] pc;
  logic        stale_q;      // HOLD entered with a killed response still in flight
  logic        req_hs;
  logic        rsp_owed;     // memory still owes a response after this cycle
  logic        tgt_misalign;
  logic [63:0] target;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign tgt_misalign = (redirect_target[1:0] != 2'b00);
  assign target       = redirect_target;
`else
  assign tgt_misalign = 1'b0;
  assign target       = redirect_target & ~64'h3;
`endif

  // Request valid is gated by rst_n so nothing is offered while reset is held.
  assign imem_req_valid = rst_n && (state == S_REQ);
  assign imem_req_addr  = pc;
  assign req_hs         = imem_req_valid && imem_req_ready;
  assign inst_pc_plus4  = inst_pc + 64'd4;

  assign rsp_owed = req_hs ||
                    (((state == S_WAIT) || (state == S_WAIT_KILL) || stale_q) && !imem_rsp_valid);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_REQ;
      pc             <= RESET_PC;
      inst_valid     <= 1'b0;
      inst           <= NOP_INST;
      inst_pc        <= RESET_PC;
      fetch_fault    <= 1'b0;
      fetch_misalign <= 1'b0;
      stale_q        <= 1'b0;
    end else begin
      if (stale_q && imem_rsp_valid) begin
        stale_q <= 1'b0;
      end
      if (redirect_valid) begin
        pc <= target;
        if (tgt_misalign) begin
          // Trap in place of a fetch: present a NOP carrying the bad PC.
          state          <= S_HOLD;
          inst_valid     <= 1'b1;
          inst           <= NOP_INST;
          inst_pc        <= target;
          fetch_fault    <= 1'b0;
          fetch_misalign <= 1'b1;
          stale_q        <= rsp_owed;
        end else begin
          inst_valid     <= 1'b0;
          inst           <= NOP_INST;
          fetch_fault    <= 1'b0;
          fetch_misalign <= 1'b0;
          case (state)
            S_REQ:               state <= req_hs ? S_WAIT_KILL : S_REQ;
            // A response landing in the redirect cycle is the one we were
            // waiting for; dropping it leaves nothing outstanding.
            S_WAIT, S_WAIT_KILL: state <= imem_rsp_valid ? S_REQ : S_WAIT_KILL;
            default:             state <= rsp_owed ? S_WAIT_KILL : S_REQ;
          endcase
        end
      end else begin
        case (state)
          S_REQ: begin
            if (req_hs) begin
              state <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (imem_rsp_valid) begin
              inst           <= imem_rsp_data;
              fetch_fault    <= imem_rsp_error;
              fetch_misalign <= 1'b0;
              inst_pc        <= pc;
              inst_valid     <= 1'b1;
              state          <= S_HOLD;
            end
          end
          S_WAIT_KILL: begin
            if (imem_rsp_valid) begin
              state <= S_REQ;
            end
          end
          default: begin
            if (inst_ready) begin
              pc             <= pc + 64'd4;
              inst_valid     <= 1'b0;
              inst           <= NOP_INST;
              fetch_fault    <= 1'b0;
              fetch_misalign <= 1'b0;
              state          <= rsp_owed ? S_WAIT_KILL : S_REQ;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
`timescale 1ns/1ps
module tb_inst_fetch_unit;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_0040_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_error;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic [63:0] inst_pc_plus4;
  logic        fetch_fault;
  logic        fetch_misalign;
  logic        redirect_valid;
  logic [63:0] redirect_target;

  always #5 clk = ~clk;

  inst_fetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .imem_rsp_error  (imem_rsp_error),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .inst_pc_plus4   (inst_pc_plus4),
    .fetch_fault     (fetch_fault),
    .fetch_misalign  (fetch_misalign),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] data;
    logic        err;
  } exp_t;

  typedef struct {
    int              dly;       // cycles req_valid waits before ready
    int              lat;       // edges from handshake to response
    logic            redir;     // start from 'start' via a redirect in REQ
    logic [63:0]     start;
    logic [63:0]     err_addr;  // address answered with imem_rsp_error
    int              period;    // expected cycles between instructions
    logic [3:0][63:0] addr;     // expected request addresses in order
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[4];
  int          n_vec = 0;
  int          n_bad = 0;

  logic        pend;
  int          pend_cnt;
  logic [63:0] pend_addr;
  int          wait_cnt;
  logic [63:0] held_addr;
  int          n_hs;
  int          n_ret;
  logic [63:0] hs_addr[8];
  int          ret_cyc[8];

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0F0F;
  endfunction

  function automatic vec_t mk(input int dly, input int lat, input logic redir,
                              input logic [63:0] start, input logic [63:0] err_addr,
                              input int period, input logic [63:0] a0, input logic [63:0] a1,
                              input logic [63:0] a2, input logic [63:0] a3);
    vec_t v;
    v.dly = dly; v.lat = lat; v.redir = redir; v.start = start;
    v.err_addr = err_addr; v.period = period;
    v.addr[0] = a0; v.addr[1] = a1; v.addr[2] = a2; v.addr[3] = a3;
    return v;
  endfunction

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock; returns at the following falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    imem_req_ready  = 1'b0;
    imem_rsp_valid  = 1'b0;
    imem_rsp_data   = 32'h0;
    imem_rsp_error  = 1'b0;
    inst_ready      = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 64'h0;
    cyc();
    cyc();
  endtask

  // Memory model: drives the response and ready inputs for the coming edge.
  task automatic mem_step(input vec_t v);
    exp_t e;
    logic busy;
    busy           = pend;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    imem_rsp_error = 1'b0;
    if (pend) begin
      if (pend_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_addr);
        imem_rsp_error = (pend_addr == v.err_addr);
        pend           = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    imem_req_ready = 1'b0;
    if (imem_req_valid) begin
      chk1("no_req_while_busy", busy, 1'b0);
      if (wait_cnt == 0) held_addr = imem_req_addr;
      else chk64("req_addr_stable", imem_req_addr, held_addr);
      if (wait_cnt >= v.dly) begin
        imem_req_ready = 1'b1;
        pend      = 1'b1;
        pend_cnt  = v.lat - 1;
        pend_addr = imem_req_addr;
        e.pc   = imem_req_addr;
        e.data = mem_word(imem_req_addr);
        e.err  = (imem_req_addr == v.err_addr);
        sb.push_back(e);
        if (n_hs < 8) hs_addr[n_hs] = imem_req_addr;
        n_hs++;
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end
  endtask

  task automatic run_stream(input int k);
    vec_t v;
    exp_t e;
    int   c;
    v = vecs[k];
    do_reset();
    rst_n = 1'b1;
    sb.delete();
    pend = 1'b0; pend_cnt = 0; wait_cnt = 0; n_hs = 0; n_ret = 0;
    inst_ready = 1'b1;
    if (v.redir) begin
      redirect_valid  = 1'b1;
      redirect_target = v.start;
      cyc();
      redirect_valid  = 1'b0;
    end
    c = 0;
    while (n_ret < 4 && c < 300) begin
      mem_step(v);
      if (inst_valid) begin
        if (sb.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL sb_underflow[%0d]: inst_valid at pc %h with nothing expected", k, inst_pc);
        end else begin
          e = sb.pop_front();
          chk32($sformatf("sb_inst[%0d]", k), inst, e.data);
          chk64($sformatf("sb_pc[%0d]", k), inst_pc, e.pc);
          chk64($sformatf("sb_pc4[%0d]", k), inst_pc_plus4, e.pc + 64'd4);
          chk1($sformatf("sb_fault[%0d]", k), fetch_fault, e.err);
          chk1($sformatf("sb_misalign[%0d]", k), fetch_misalign, 1'b0);
        end
        if (n_ret < 8) ret_cyc[n_ret] = c;
        n_ret++;
      end
      cyc();
      c++;
    end
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;
    chk_int($sformatf("retired[%0d]", k), n_ret, 4);
    chk_int($sformatf("requests[%0d]", k), n_hs, 4);
    for (int i = 0; i < 4; i++)
      if (i < n_hs) chk64($sformatf("req_addr[%0d][%0d]", k, i), hs_addr[i], v.addr[i]);
    for (int i = 1; i < 4; i++)
      if (i < n_ret) chk_int($sformatf("period[%0d][%0d]", k, i), ret_cyc[i] - ret_cyc[i-1], v.period);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk(0, 1, 1'b0, 64'h0, 64'h3, 3,
                 64'h40_0000, 64'h40_0004, 64'h40_0008, 64'h40_000C);
    vecs[1] = mk(4, 1, 1'b0, 64'h0, 64'h40_000C, 7,
                 64'h40_0000, 64'h40_0004, 64'h40_0008, 64'h40_000C);
    vecs[2] = mk(0, 3, 1'b1, 64'h1000, 64'h1004, 5,
                 64'h1000, 64'h1004, 64'h1008, 64'h100C);
    vecs[3] = mk(2, 2, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 6,
                 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h4);

    @(negedge clk);

    // Reset state
    do_reset();
    chk1("rst_req_valid", imem_req_valid, 1'b0);
    chk64("rst_req_addr", imem_req_addr, RESET_PC);
    chk1("rst_inst_valid", inst_valid, 1'b0);
    chk32("rst_inst", inst, NOP_INST);
    chk64("rst_inst_pc", inst_pc, RESET_PC);
    chk64("rst_inst_pc4", inst_pc_plus4, RESET_PC + 64'd4);
    chk1("rst_fault", fetch_fault, 1'b0);
    chk1("rst_misalign", fetch_misalign, 1'b0);
    rst_n = 1'b1;
    #1;
    chk1("rst_release_req", imem_req_valid, 1'b1);

    // Streaming vectors through the memory model and scoreboard
    for (int k = 0; k < 4; k++) run_stream(k);

    // Redirect while waiting: stale response is dropped
    do_reset();
    rst_n = 1'b1;
    imem_req_ready = 1'b1; cyc(); imem_req_ready = 1'b0;
    chk1("t3_wait_no_req", imem_req_valid, 1'b0);
    redirect_valid = 1'b1; redirect_target = 64'h80; cyc(); redirect_valid = 1'b0;
    chk1("t3_kill_no_req", imem_req_valid, 1'b0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF; cyc(); imem_rsp_valid = 1'b0;
    chk1("t3_stale_dropped", inst_valid, 1'b0);
    chk1("t3_req_valid", imem_req_valid, 1'b1);
    chk64("t3_req_addr", imem_req_addr, 64'h80);
    imem_req_ready = 1'b1; cyc(); imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0010_0093; cyc(); imem_rsp_valid = 1'b0;
    chk1("t3_inst_valid", inst_valid, 1'b1);
    chk32("t3_inst", inst, 32'h0010_0093);
    chk64("t3_inst_pc", inst_pc, 64'h80);
    chk64("t3_inst_pc4", inst_pc_plus4, 64'h84);
    cyc(); cyc();
    chk1("hold_valid", inst_valid, 1'b1);
    chk32("hold_inst", inst, 32'h0010_0093);
    chk1("hold_no_req", imem_req_valid, 1'b0);

    // Retire and redirect in the same cycle: target wins over pc+4
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 64'h200; cyc();
    inst_ready = 1'b0; redirect_valid = 1'b0;
    chk1("t4_retired", inst_valid, 1'b0);
    chk1("t4_req_valid", imem_req_valid, 1'b1);
    chk64("t4_req_addr", imem_req_addr, 64'h200);

    // Redirect of an unaccepted request
    redirect_valid = 1'b1; redirect_target = 64'h300; cyc(); redirect_valid = 1'b0;
    chk1("req_redir_valid", imem_req_valid, 1'b1);
    chk64("req_redir_addr", imem_req_addr, 64'h300);

    // Redirect in the handshake cycle: the accepted request's response is dropped
    imem_req_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 64'h400; cyc();
    imem_req_ready = 1'b0; redirect_valid = 1'b0;
    chk1("hs_redir_no_req", imem_req_valid, 1'b0);
    chk64("hs_redir_addr", imem_req_addr, 64'h400);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_0BAD; cyc(); imem_rsp_valid = 1'b0;
    chk1("hs_redir_dropped", inst_valid, 1'b0);
    chk1("hs_redir_req", imem_req_valid, 1'b1);
    chk64("hs_redir_req_addr", imem_req_addr, 64'h400);

    // Reset in the middle of a transaction
    imem_req_ready = 1'b1; cyc(); imem_req_ready = 1'b0;
    rst_n = 1'b0; cyc();
    chk1("midrst_req_valid", imem_req_valid, 1'b0);
    chk64("midrst_addr", imem_req_addr, RESET_PC);
    chk1("midrst_inst_valid", inst_valid, 1'b0);
    rst_n = 1'b1; cyc();
    chk1("midrst_release_req", imem_req_valid, 1'b1);
    chk64("midrst_release_addr", imem_req_addr, RESET_PC);

    // Misaligned redirect target
    redirect_valid = 1'b1; redirect_target = 64'h102; cyc(); redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    chk1("t6_inst_valid", inst_valid, 1'b1);
    chk1("t6_misalign", fetch_misalign, 1'b1);
    chk32("t6_inst", inst, NOP_INST);
    chk64("t6_inst_pc", inst_pc, 64'h102);
    chk1("t6_no_req", imem_req_valid, 1'b0);
    inst_ready = 1'b1; cyc(); inst_ready = 1'b0;
    chk1("t6_retired", inst_valid, 1'b0);
    chk1("t6_req_valid", imem_req_valid, 1'b1);
    chk64("t6_req_addr", imem_req_addr, 64'h106);
`else
    chk1("t6_req_valid", imem_req_valid, 1'b1);
    chk64("t6_req_addr", imem_req_addr, 64'h100);
    chk1("t6_inst_valid", inst_valid, 1'b0);
    chk1("t6_misalign", fetch_misalign, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
